// File: rtl/nios2_debug_pkg.sv
// Shared definitions for the on-chip debug memory controller.
//   JDO_*_LSB / JDO_RDGO_BIT : field positions inside the 38-bit jdo word
//   state_t                  : controller states (JTAG read pending, CPU read pending)
//   MONDREG_W                : width of the monitor data register
package nios2_debug_pkg;
    localparam int JDO_ADDR_LSB  = 18;
    localparam int JDO_RDGO_BIT  = 17;
    localparam int JDO_WDATA_LSB = 3;
    localparam int MONDREG_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        J_RD = 2'd1,
        C_RD = 2'd2
    } state_t;
endpackage

// File: rtl/nios2_debug_ocimem_ram.sv
// Single-port debug RAM, DEPTH x 32 bits, synchronous read with one cycle of
// latency, per-byte write enables. Read-during-write returns the old word.
//   clk    : clock
//   addr   : word address
//   we     : write enable
//   be     : byte lane enables for the write
//   wdata  : write data
//   q      : registered read data (word at addr sampled on the previous edge)
module nios2_debug_ocimem_ram
    import nios2_debug_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 we,
    input  logic [3:0]           be,
    input  logic [MONDREG_W-1:0] wdata,
    output logic [MONDREG_W-1:0] q
);
    logic [MONDREG_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        q <= mem[addr];
    end
endmodule

// File: rtl/nios2_debug_ocimem_ctrl.sv
// JTAG / CPU access controller for the on-chip debug RAM.
// JTAG strobes from the debug-slave sysclk stage own the single RAM port in
// the cycle they arrive; the CPU Avalon-MM slave only gets cycles with no strobe.
//   clk, reset                 : clock, synchronous active-high reset
//   jdo                        : debug word (addr [25:18], rd_go [17], wdata [34:3])
//   take_action_ocimem_a       : load address / start read
//   take_no_action_ocimem_a    : read next word
//   take_action_ocimem_b       : write word at MonAReg
//   MonDReg                    : last JTAG read data
//   monitor_ready              : JTAG read data valid (sticky until next strobe)
//   monitor_error              : last JTAG access was out of range (sticky)
//   avs_*                      : CPU-side Avalon-MM slave
module nios2_debug_ocimem_ctrl
    import nios2_debug_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [37:0]          jdo,
    input  logic                 take_action_ocimem_a,
    input  logic                 take_no_action_ocimem_a,
    input  logic                 take_action_ocimem_b,
    output logic [MONDREG_W-1:0] MonDReg,
    output logic                 monitor_ready,
    output logic                 monitor_error,
    input  logic [ADDR_W-1:0]    avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    input  logic [3:0]           avs_byteenable,
    output logic [31:0]          avs_readdata,
    output logic                 avs_waitrequest
);
    // The JTAG address field is always 8 bits wide; range checks use all of
    // it so that addresses beyond a smaller DEPTH are reported, not aliased.
    logic [7:0]           jdo_addr;
    logic                 jdo_rd_go;
    logic [31:0]          jdo_wdata;
    logic                 unused_jdo;

    logic [7:0]           mon_a_reg;
    state_t               jtag_state;
    state_t               cpu_state;
    logic                 j_oor_q;

    logic                 do_b, do_a, do_n, any_strobe;
    logic                 j_rd_issue;
    logic [7:0]           rd_addr;
    logic                 rd_oor, wr_oor;
    logic                 cpu_rd_go, cpu_wr_go;

    logic [ADDR_W-1:0]    ram_addr;
    logic                 ram_we;
    logic [3:0]           ram_be;
    logic [31:0]          ram_wdata;
    logic [31:0]          ram_q;

    function automatic logic in_range(input logic [7:0] a);
        return {1'b0, a} < 9'(DEPTH);
    endfunction

    function automatic logic [7:0] next_addr(input logic [7:0] a);
        return (int'(a) == DEPTH - 1) ? 8'd0 : a + 8'd1;
    endfunction

    assign jdo_addr   = jdo[JDO_ADDR_LSB +: 8];
    assign jdo_rd_go  = jdo[JDO_RDGO_BIT];
    assign jdo_wdata  = jdo[JDO_WDATA_LSB +: 32];
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    // Strobes should be one-hot; if not, b beats a beats no_action.
    assign do_b       = take_action_ocimem_b;
    assign do_a       = take_action_ocimem_a & ~do_b;
    assign do_n       = take_no_action_ocimem_a & ~take_action_ocimem_a & ~do_b;
    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    assign j_rd_issue = (do_a & jdo_rd_go) | do_n;
    assign rd_addr    = do_a ? jdo_addr : mon_a_reg;
    assign rd_oor     = ~in_range(rd_addr);
    assign wr_oor     = ~in_range(mon_a_reg);

    assign cpu_rd_go  = (cpu_state == IDLE) & avs_read & ~any_strobe & ~reset;
    assign cpu_wr_go  = (cpu_state == IDLE) & avs_write & ~avs_read & ~any_strobe & ~reset;

    always_comb begin
        ram_addr  = avs_address;
        ram_we    = cpu_wr_go;
        ram_be    = avs_byteenable;
        ram_wdata = avs_writedata;
        if (do_b) begin
            ram_addr  = mon_a_reg[ADDR_W-1:0];
            ram_we    = ~wr_oor & ~reset;
            ram_be    = 4'hF;
            ram_wdata = jdo_wdata;
        end else if (j_rd_issue) begin
            ram_addr  = rd_addr[ADDR_W-1:0];
            ram_we    = 1'b0;
        end
    end

    nios2_debug_ocimem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mon_a_reg     <= 8'd0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            jtag_state    <= IDLE;
            cpu_state     <= IDLE;
            j_oor_q       <= 1'b0;
        end else begin
            if (any_strobe) begin
                monitor_ready <= 1'b0;
                monitor_error <= 1'b0;
            end

            if (do_b) begin
                if (wr_oor) begin
                    monitor_error <= 1'b1;
                end else begin
                    mon_a_reg <= next_addr(mon_a_reg);
                end
            end else if (do_a && !jdo_rd_go) begin
                mon_a_reg <= jdo_addr;
            end else if (j_rd_issue) begin
                // An out-of-range read leaves the pointer at the requested address.
                mon_a_reg <= rd_oor ? rd_addr : next_addr(rd_addr);
            end

            jtag_state <= j_rd_issue ? J_RD : IDLE;
            j_oor_q    <= j_rd_issue & rd_oor;

            // A completing read takes precedence over the clear from a new
            // strobe in the same cycle, so back-to-back reads stay in order.
            if (jtag_state == J_RD) begin
                MonDReg       <= j_oor_q ? '0 : ram_q;
                monitor_ready <= 1'b1;
                monitor_error <= j_oor_q | (do_b & wr_oor);
            end

            case (cpu_state)
                IDLE:    cpu_state <= cpu_rd_go ? C_RD : IDLE;
                C_RD:    cpu_state <= IDLE;
                default: cpu_state <= IDLE;
            endcase
        end
    end

    assign avs_waitrequest = reset | ~((cpu_state == C_RD) | cpu_wr_go);
    assign avs_readdata    = (cpu_state == C_RD) ? ram_q : 32'd0;
endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
module tb_nios2_debug_ocimem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        ta_a, tna_a, ta_b;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;

    logic [31:0] mond0, rdata0;
    logic        rdy0, err0, wait0;
    logic [31:0] mond1, rdata1;
    logic        rdy1, err1, wait1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nios2_debug_ocimem_ctrl #(.DEPTH(256), .ADDR_W(8)) dut0 (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a), .take_action_ocimem_b(ta_b),
        .MonDReg(mond0), .monitor_ready(rdy0), .monitor_error(err0),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(rdata0), .avs_waitrequest(wait0)
    );

    nios2_debug_ocimem_ctrl #(.DEPTH(128), .ADDR_W(7)) dut1 (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a), .take_action_ocimem_b(ta_b),
        .MonDReg(mond1), .monitor_ready(rdy1), .monitor_error(err1),
        .avs_address(avs_address[6:0]), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(rdata1), .avs_waitrequest(wait1)
    );

    typedef struct {
        logic        rst, a, na, b, rd_go;
        logic [7:0]  jaddr;
        logic [31:0] jwd;
        logic        ard, awr;
        logic [7:0]  aadr;
        logic [31:0] awd;
        logic [3:0]  abe;
        logic        e_wait;
        logic [31:0] e_rdata, e_mond;
        logic        e_rdy, e_err;
        logic [7:0]  e_mona;
    } vec_t;

    localparam int NV = 32;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic a, input logic na, input logic b,
                         input logic rd_go, input logic [7:0] jaddr, input logic [31:0] jwd,
                         input logic ard, input logic awr, input logic [7:0] aadr,
                         input logic [31:0] awd, input logic [3:0] abe);
        reset = rst;
        ta_a  = a;
        tna_a = na;
        ta_b  = b;
        if (b) jdo = {3'b000, jwd, 3'b000};
        else   jdo = {12'd0, jaddr, rd_go, 17'd0};
        avs_read       = ard;
        avs_write      = awr;
        avs_address    = aadr;
        avs_writedata  = awd;
        avs_byteenable = abe;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    endtask

    initial begin
        logic       got;
        int         lat;
        //            rst  a    na   b    rdgo jaddr  jwd           ard  awr  aadr   awd           abe    wait rdata         mond          rdy  err  mona
        vt[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'h0,        1'b0,1'b0,8'h00};
        vt[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b1,8'h10,32'hCAFEF00D, 4'hF, 1'b0,32'h0,        32'h0,        1'b0,1'b0,8'h00};
        vt[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,8'h10,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'h0,        1'b0,1'b0,8'h11};
        vt[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFEF00D, 1'b1,1'b0,8'h11};
        vt[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,8'h20,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h20};
        vt[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,32'h1,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h21};
        vt[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,32'h2,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h22};
        vt[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,32'h3,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h23};
        vt[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h20,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h23};
        vt[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h20,32'h0,        4'h0, 1'b0,32'h1,        32'hCAFEF00D, 1'b0,1'b0,8'h23};
        vt[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h21,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h23};
        vt[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h21,32'h0,        4'h0, 1'b0,32'h2,        32'hCAFEF00D, 1'b0,1'b0,8'h23};
        vt[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h22,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h23};
        vt[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h22,32'h0,        4'h0, 1'b0,32'h3,        32'hCAFEF00D, 1'b0,1'b0,8'h23};
        vt[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b1,8'h00,32'h12345678, 4'hF, 1'b0,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h23};
        vt[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b1,8'hFF,32'hA5A5A5A5, 4'hF, 1'b0,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h23};
        vt[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b1,8'h00,32'hFFFFFFFF, 4'h2, 1'b0,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h23};
        vt[17] = '{1'b0,1'b1,1'b0,1'b0,1'b0,8'hFF,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'hFF};
        vt[18] = '{1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h00};
        vt[19] = '{1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'hA5A5A5A5, 1'b1,1'b0,8'h01};
        vt[20] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'h1234FF78, 1'b1,1'b0,8'h01};
        vt[21] = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,32'hDEADBEEF, 1'b1,1'b0,8'h01,32'h0,        4'h0, 1'b1,32'h0,        32'h1234FF78, 1'b0,1'b0,8'h02};
        vt[22] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h01,32'h0,        4'h0, 1'b1,32'h0,        32'h1234FF78, 1'b0,1'b0,8'h02};
        vt[23] = '{1'b0,1'b1,1'b0,1'b0,1'b1,8'h10,32'h0,        1'b1,1'b0,8'h01,32'h0,        4'h0, 1'b0,32'hDEADBEEF, 32'h1234FF78, 1'b0,1'b0,8'h11};
        vt[24] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFEF00D, 1'b1,1'b0,8'h11};
        vt[25] = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,32'h11111111, 1'b0,1'b1,8'h11,32'h22222222, 4'hF, 1'b1,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h12};
        vt[26] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b1,8'h11,32'h22222222, 4'hF, 1'b0,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h12};
        vt[27] = '{1'b0,1'b1,1'b0,1'b0,1'b1,8'h11,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFEF00D, 1'b0,1'b0,8'h12};
        vt[28] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'h22222222, 1'b1,1'b0,8'h12};
        vt[29] = '{1'b0,1'b1,1'b0,1'b0,1'b1,8'h10,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'h22222222, 1'b0,1'b0,8'h11};
        vt[30] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'h0,        1'b0,1'b0,8'h00};
        vt[31] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,        4'h0, 1'b1,32'h0,        32'h0,        1'b0,1'b0,8'h00};

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].rst, vt[i].a, vt[i].na, vt[i].b, vt[i].rd_go, vt[i].jaddr, vt[i].jwd,
                  vt[i].ard, vt[i].awr, vt[i].aadr, vt[i].awd, vt[i].abe);
            #2;
            chk($sformatf("v%0d waitrequest", i), 32'(wait0), 32'(vt[i].e_wait));
            chk($sformatf("v%0d readdata", i), rdata0, vt[i].e_rdata);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d MonDReg", i), mond0, vt[i].e_mond);
            chk($sformatf("v%0d ready", i), 32'(rdy0), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d error", i), 32'(err0), 32'(vt[i].e_err));
            chk($sformatf("v%0d MonAReg", i), 32'(dut0.mon_a_reg), 32'(vt[i].e_mona));
        end

        // Out-of-range handling on the DEPTH=128 instance.
        idle();
        avs_write = 1'b1; avs_address = 8'h10; avs_writedata = 32'h0BADC0DE; avs_byteenable = 4'hF;
        #2;
        chk("oor cpu write wait", 32'(wait1), 32'd0);
        @(posedge clk); #1;

        idle();
        ta_a = 1'b1; jdo = {12'd0, 8'h90, 1'b1, 17'd0};
        @(posedge clk); #1;
        chk("oor rd strobe MonAReg", 32'(dut1.mon_a_reg), 32'h90);
        chk("oor rd strobe ready", 32'(rdy1), 32'd0);

        idle();
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 4 && !got; k++) begin
            @(posedge clk); #1;
            if (rdy1) begin
                got = 1'b1;
                lat = k;
            end
        end
        chk("oor rd ready seen", 32'(got), 32'd1);
        chk("oor rd latency", 32'(lat), 32'd1);
        chk("oor rd MonDReg", mond1, 32'd0);
        chk("oor rd error", 32'(err1), 32'd1);
        chk("oor rd MonAReg", 32'(dut1.mon_a_reg), 32'h90);

        ta_b = 1'b1; jdo = {3'b000, 32'hFFFFFFFF, 3'b000};
        @(posedge clk); #1;
        chk("oor wr error", 32'(err1), 32'd1);
        chk("oor wr ready", 32'(rdy1), 32'd0);
        chk("oor wr MonAReg", 32'(dut1.mon_a_reg), 32'h90);

        idle();
        avs_read = 1'b1; avs_address = 8'h10;
        #2;
        chk("oor cpu rd wait1", 32'(wait1), 32'd1);
        @(posedge clk); #1;
        #1;
        chk("oor cpu rd wait0", 32'(wait1), 32'd0);
        chk("oor ram unchanged", rdata1, 32'h0BADC0DE);
        @(posedge clk); #1;
        idle();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
